// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a per-register busy scoreboard.
// Reads are combinational and can optionally see same-cycle writes (bypass).
// Writes clear a register's busy bit; reservations set it and win over a
// same-cycle write, because that reservation names a newer producer.

`ifndef WORD
`define WORD 8
`endif

module regfile_mp #(
  parameter int                    WIDTH         = 4*`WORD,
  parameter int                    ADDR_SPACE    = 5,
  parameter int                    REG_AMOUNT    = 32,
  parameter logic [ADDR_SPACE-1:0] ZERO_REGISTER = '0,
  parameter int                    READ_PORTS    = 2,
  parameter int                    WRITE_PORTS   = 2,
  parameter int                    BYPASS        = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [READ_PORTS*ADDR_SPACE-1:0]  rd_addr,
  output logic [READ_PORTS*WIDTH-1:0]       rd_data,
  output logic [READ_PORTS-1:0]             rd_busy,
  input  logic [WRITE_PORTS-1:0]            wr_en,
  input  logic [WRITE_PORTS*ADDR_SPACE-1:0] wr_addr,
  input  logic [WRITE_PORTS*WIDTH-1:0]      wr_data,
  input  logic                              rsv_en,
  input  logic [ADDR_SPACE-1:0]             rsv_addr,
  output logic [REG_AMOUNT-1:0]             busy_vec
);

  logic [WIDTH-1:0]      data_reg  [REG_AMOUNT];
  logic [WIDTH-1:0]      data_next [REG_AMOUNT];
  logic [REG_AMOUNT-1:0] busy_reg;
  logic [REG_AMOUNT-1:0] busy_next;

  // An address names real storage only if it is in range and not the zero register.
  function automatic logic addr_ok(input logic [ADDR_SPACE-1:0] a);
    return (a != ZERO_REGISTER) && (int'(a) < REG_AMOUNT);
  endfunction

  // Next state per register: writes in port order (highest port wins),
  // then reservation overrides busy, then the zero register is pinned to 0.
  always_comb begin
    data_next = data_reg;
    busy_next = busy_reg;
    for (int r = 0; r < REG_AMOUNT; r++) begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (wr_en[p] && (wr_addr[p*ADDR_SPACE +: ADDR_SPACE] == ADDR_SPACE'(r))) begin
          data_next[r] = wr_data[p*WIDTH +: WIDTH];
          busy_next[r] = 1'b0;
        end
      end
      if (rsv_en && (rsv_addr == ADDR_SPACE'(r))) begin
        busy_next[r] = 1'b1;
      end
      if (ADDR_SPACE'(r) == ZERO_REGISTER) begin
        data_next[r] = '0;
        busy_next[r] = 1'b0;
      end
    end
  end

  // State register: synchronous active-low reset clears data and busy bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_AMOUNT; r++) begin
        data_reg[r] <= '0;
      end
      busy_reg <= '0;
    end else begin
      data_reg <= data_next;
      busy_reg <= busy_next;
    end
  end

  assign busy_vec = busy_reg;

  // One combinational read path per read port.
  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rd
    logic [ADDR_SPACE-1:0] addr;
    logic [WIDTH-1:0]      val;
    logic                  bsy;

    assign addr = rd_addr[gi*ADDR_SPACE +: ADDR_SPACE];

    // Stored value, optionally overridden by the winning same-cycle write;
    // a forwarded write resolves the dependency so busy reads as 0.
    always_comb begin
      val = '0;
      bsy = 1'b0;
      if (addr_ok(addr)) begin
        val = data_reg[addr];
        bsy = busy_reg[addr];
        if (BYPASS != 0) begin
          for (int p = 0; p < WRITE_PORTS; p++) begin
            if (wr_en[p] && (wr_addr[p*ADDR_SPACE +: ADDR_SPACE] == addr)) begin
              val = wr_data[p*WIDTH +: WIDTH];
              bsy = 1'b0;
            end
          end
        end
      end
    end

    assign rd_data[gi*WIDTH +: WIDTH] = val;
    assign rd_busy[gi]                = bsy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench driving two register files from the same
// stimulus: u_byp (BYPASS=1, 24 registers) and u_nob (BYPASS=0, 32 registers).
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;

  logic [31:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic [23:0] busy_vec_a;
  logic [31:0] busy_vec_b;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_mp #(.WIDTH(16), .ADDR_SPACE(5), .REG_AMOUNT(24), .ZERO_REGISTER(5'd0),
               .READ_PORTS(2), .WRITE_PORTS(2), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec_a)
  );

  regfile_mp #(.WIDTH(16), .ADDR_SPACE(5), .REG_AMOUNT(32), .ZERO_REGISTER(5'd0),
               .READ_PORTS(2), .WRITE_PORTS(2), .BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    $display("[TB] check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    wr_en   = 2'b00;
    wr_addr = '0;
    wr_data = '0;
    rsv_en  = 1'b0;
    rsv_addr = '0;
  endtask

  // Advance through one rising edge and return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    rd_addr = {5'd6, 5'd5};
    #1;
    chk("reset_busy_a", 32'(busy_vec_a), 32'h0);
    chk("reset_busy_b", busy_vec_b, 32'h0);
    chk("reset_rd_r5", 32'(rd_data_a[15:0]), 32'h0);

    // Write 0xDEAD to r5 and reserve it in the same cycle
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {16'h0, 16'hDEAD};
    rsv_en = 1'b1; rsv_addr = 5'd5;
    tick();
    idle();
    #1;
    chk("pre_rst_r5", 32'(rd_data_a[15:0]), 32'hDEAD);
    chk("pre_rst_busy", 32'(busy_vec_a), 32'h20);

    // Reset mid-operation with a write and reservation that must be lost
    rst_n = 1'b0;
    wr_en = 2'b10; wr_addr = {5'd6, 5'd0}; wr_data = {16'h1111, 16'h0};
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    chk("rst_r5", 32'(rd_data_a[15:0]), 32'h0);
    chk("rst_r6_lost", 32'(rd_data_a[31:16]), 32'h0);
    chk("rst_busy_a", 32'(busy_vec_a), 32'h0);
    chk("rst_busy_b", busy_vec_b, 32'h0);

    // Reserve r7 so the bypassed write can be seen to resolve busy
    rsv_en = 1'b1; rsv_addr = 5'd7;
    tick();
    idle();
    rd_addr = {5'd0, 5'd7};
    #1;
    chk("rsv7_busy_vec", 32'(busy_vec_a), 32'h80);
    chk("rsv7_rd_busy", 32'(rd_busy_a[0]), 32'h1);

    // Bypass: write 0x1234 to r7 while port 0 reads it
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {16'h0, 16'h1234};
    #1;
    chk("byp_data_a", 32'(rd_data_a[15:0]), 32'h1234);
    chk("byp_busy_a", 32'(rd_busy_a[0]), 32'h0);
    chk("nobyp_data_b", 32'(rd_data_b[15:0]), 32'h0);
    chk("nobyp_busy_b", 32'(rd_busy_b[0]), 32'h1);
    tick();
    idle();
    #1;
    chk("nobyp_next_b", 32'(rd_data_b[15:0]), 32'h1234);
    chk("wr7_busy_clr", 32'(busy_vec_a), 32'h0);

    // Write conflict: both ports write r3, port 1 must win
    wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {16'hBBBB, 16'hAAAA};
    rd_addr = {5'd3, 5'd0};
    #1;
    chk("conf_byp_a", 32'(rd_data_a[31:16]), 32'hBBBB);
    tick();
    idle();
    #1;
    chk("conf_r3_a", 32'(rd_data_a[31:16]), 32'hBBBB);
    chk("conf_r3_b", 32'(rd_data_b[31:16]), 32'hBBBB);

    // Scoreboard: reserve r9
    rsv_en = 1'b1; rsv_addr = 5'd9;
    rd_addr = {5'd3, 5'd9};
    tick();
    idle();
    #1;
    chk("sb_rsv9_vec", 32'(busy_vec_a), 32'h200);
    chk("sb_rsv9_rdb", 32'(rd_busy_a[0]), 32'h1);

    // Write r9 with 0x55 on port 1 releases it
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {16'h0055, 16'h0};
    tick();
    idle();
    #1;
    chk("sb_wr9_vec", 32'(busy_vec_a), 32'h0);
    chk("sb_wr9_data", 32'(rd_data_a[15:0]), 32'h55);
    chk("sb_wr9_rdb", 32'(rd_busy_a[0]), 32'h0);

    // Reserve plus write on r9 in one cycle: reservation wins
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {16'h0, 16'h0066};
    rsv_en = 1'b1; rsv_addr = 5'd9;
    #1;
    chk("sb_rw9_byp_rdb", 32'(rd_busy_a[0]), 32'h0);
    tick();
    idle();
    #1;
    chk("sb_rw9_vec_a", 32'(busy_vec_a), 32'h200);
    chk("sb_rw9_vec_b", busy_vec_b, 32'h200);
    chk("sb_rw9_data", 32'(rd_data_a[15:0]), 32'h66);
    chk("sb_rw9_rdb", 32'(rd_busy_a[0]), 32'h1);

    // Zero register: write and reserve r0
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {16'h0, 16'hFFFF};
    rsv_en = 1'b1; rsv_addr = 5'd0;
    rd_addr = {5'd0, 5'd0};
    #1;
    chk("zero_byp_a", 32'(rd_data_a[15:0]), 32'h0);
    tick();
    idle();
    #1;
    chk("zero_data_a", 32'(rd_data_a[15:0]), 32'h0);
    chk("zero_data_b", 32'(rd_data_b[15:0]), 32'h0);
    chk("zero_rdb_a", 32'(rd_busy_a[0]), 32'h0);
    chk("zero_vec_a", 32'(busy_vec_a), 32'h200);

    // Out of range for the 24-register instance, valid for the 32-register one
    wr_en = 2'b01; wr_addr = {5'd0, 5'd30}; wr_data = {16'h0, 16'h0077};
    rsv_en = 1'b1; rsv_addr = 5'd30;
    rd_addr = {5'd30, 5'd3};
    #1;
    chk("oor_byp_a", 32'(rd_data_a[31:16]), 32'h0);
    tick();
    idle();
    #1;
    chk("oor_rd30_a", 32'(rd_data_a[31:16]), 32'h0);
    chk("oor_rdb30_a", 32'(rd_busy_a[1]), 32'h0);
    chk("oor_r3_a", 32'(rd_data_a[15:0]), 32'hBBBB);
    chk("oor_vec_a", 32'(busy_vec_a), 32'h200);
    chk("inr_rd30_b", 32'(rd_data_b[31:16]), 32'h77);
    chk("inr_vec_b", busy_vec_b, 32'h4000_0200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
